// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter
// Sequences every access to the 512x32 level-sensitive RAM and shares it
// between the instruction fetch port (f_*, read-only) and the load/store
// data port (d_*, read/write). The RAM address and write data are latched
// before any strobe rises and stay put until the next grant. The RAM
// therefore never sees a strobe while its address is moving.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   -> on a tie, the port not granted last wins (d wins the first tie)
//   undefined -> fixed priority, d over f
//
// Ports
//   clk, clr             clock, synchronous active-high reset
//   f_req/f_addr         fetch request, held until f_ack
//   f_rdata/f_ack        last fetched word, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata  data request (store when d_we=1), held until d_ack
//   d_rdata/d_ack        last loaded word, one-cycle completion pulse
//   ram_read/ram_write   RAM strobes, never both high
//   ram_address/ram_wdata  latched RAM address and write data
//   ram_rdata            RAM read data, only meaningful while ram_read is high
//   busy                 high whenever the sequencer is not idle
module ram_access_arbiter #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, GRANT, ACCESS, DONE} state_t;

    // The counter only needs to hold WAIT_CYCLES-1.
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;
    logic             owner_d;
    logic             we_q;
    logic             any_req;
    logic             grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic             last_d;
`endif

    // Arbitration decision, only acted on in IDLE.
    always_comb begin
        any_req = f_req | d_req;
`ifdef ARB_ROUND_ROBIN_EN
        // On a tie, the port that did not win last time gets the RAM.
        grant_d = d_req & (~f_req | ~last_d);
`else
        grant_d = d_req;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE -> GRANT -> ACCESS (WAIT_CYCLES) -> DONE -> IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = GRANT;
            GRANT:   next_state = ACCESS;
            ACCESS:  if (count == '0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Transaction latches, wait counter and read-data capture.
    // The fetch port has no write data, so a fetch grant leaves ram_wdata alone.
    always_ff @(posedge clk) begin
        if (clr) begin
            owner_d     <= 1'b0;
            we_q        <= 1'b0;
            count       <= '0;
            ram_address <= '0;
            ram_wdata   <= '0;
            f_rdata     <= '0;
            d_rdata     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_d     <= grant_d;
                        we_q        <= grant_d & d_we;
                        ram_address <= grant_d ? d_addr : f_addr;
                        if (grant_d) begin
                            ram_wdata <= d_wdata;
                        end
`ifdef ARB_ROUND_ROBIN_EN
                        last_d      <= grant_d;
`endif
                    end
                end
                GRANT: begin
                    count <= CNT_W'(WAIT_CYCLES - 1);
                end
                ACCESS: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else if (!we_q) begin
                        // Last strobe cycle: RAM output has settled.
                        if (owner_d) begin
                            d_rdata <= ram_rdata;
                        end else begin
                            f_rdata <= ram_rdata;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from state; strobes only ever high in ACCESS.
    always_comb begin
        ram_read  = (state == ACCESS) & ~we_q;
        ram_write = (state == ACCESS) & we_q;
        f_ack     = (state == DONE) & ~owner_d;
        d_ack     = (state == DONE) & owner_d;
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// tb_ram_access_arbiter
// Drives two arbiters (WAIT_CYCLES=1 and WAIT_CYCLES=3), each attached to its
// own level-sensitive RAM model. Expected read data is queued when a request
// is issued and is compared when the matching ack arrives.
module tb_ram_access_arbiter;

   localparam int AW = 9;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic clr;
   logic preload;

   // Instance with the default single wait cycle
   logic          f_req, d_req, d_we, f_ack, d_ack, ram_read, ram_write, busy;
   logic [AW-1:0] f_addr, d_addr, ram_address;
   logic [DW-1:0] d_wdata, f_rdata, d_rdata, ram_wdata, ram_rdata;

   // Instance with three wait cycles
   logic          s_f_req, s_d_req, s_d_we, s_f_ack, s_d_ack, s_ram_read, s_ram_write, s_busy;
   logic [AW-1:0] s_f_addr, s_d_addr, s_ram_address;
   logic [DW-1:0] s_d_wdata, s_f_rdata, s_d_rdata, s_ram_wdata, s_ram_rdata;

   logic [DW-1:0] mem   [512];
   logic [DW-1:0] mem_s [512];
   logic [DW-1:0] ref_mem   [512];
   logic [DW-1:0] ref_mem_s [512];

   logic [DW-1:0] exp_f_q [$];
   logic [DW-1:0] exp_d_q [$];
   logic [DW-1:0] exp_s_q [$];
   logic [DW-1:0] exp_f_last, exp_d_last, exp_s_last;
   bit            last_grant_d;

   int checks = 0;
   int errors = 0;
   int strobe_viol = 0;

   always #5 clk = ~clk;

   ram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(1)) dut (
      .clk(clk), .clr(clr),
      .f_req(f_req), .f_addr(f_addr), .f_rdata(f_rdata), .f_ack(f_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
   );

   ram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(3)) dut_slow (
      .clk(clk), .clr(clr),
      .f_req(s_f_req), .f_addr(s_f_addr), .f_rdata(s_f_rdata), .f_ack(s_f_ack),
      .d_req(s_d_req), .d_we(s_d_we), .d_addr(s_d_addr), .d_wdata(s_d_wdata),
      .d_rdata(s_d_rdata), .d_ack(s_d_ack),
      .ram_read(s_ram_read), .ram_write(s_ram_write), .ram_address(s_ram_address),
      .ram_wdata(s_ram_wdata), .ram_rdata(s_ram_rdata), .busy(s_busy)
   );

   function automatic logic [DW-1:0] initWord(input int i);
      if (i == 16) return 32'h1234_5678;
      return 32'hC0DE_0000 + 32'(i);
   endfunction

   // Level-sensitive RAMs: a write lands on every edge the write strobe is high.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 512; i++) begin
            mem[i]   = initWord(i);
            mem_s[i] = initWord(i);
         end
      end else begin
         if (ram_write)   mem[ram_address]     = ram_wdata;
         if (s_ram_write) mem_s[s_ram_address] = s_ram_wdata;
      end
   end

   // Read data is only driven while reading; a junk pattern stands in for the floating bus.
   assign ram_rdata   = ram_read   ? mem[ram_address]     : 32'hBAD0_BAD0;
   assign s_ram_rdata = s_ram_read ? mem_s[s_ram_address] : 32'hBAD0_BAD0;

   // Strobes must never overlap and never appear while idle.
   always @(negedge clk) begin
      if ((ram_read === 1'b1 && ram_write === 1'b1) || (s_ram_read === 1'b1 && s_ram_write === 1'b1))
         strobe_viol++;
      if ((ram_read === 1'b1 || ram_write === 1'b1) && busy !== 1'b1)
         strobe_viol++;
      if ((s_ram_read === 1'b1 || s_ram_write === 1'b1) && s_busy !== 1'b1)
         strobe_viol++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete transaction on one port; checks latency, strobe count,
   // address/data stability during strobes, read data and post-op holding.
   task automatic applyStimulus(input string tag, input bit slow, input bit is_d,
                                input bit we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata);
      int            cyc, strobes, bad, exp_lat, exp_strobes;
      bit            acked;
      logic          r, w, ack, wrong_ack;
      logic [AW-1:0] a;
      logic [DW-1:0] wd, got;
      exp_lat     = slow ? 5 : 3;
      exp_strobes = slow ? 3 : 1;
      if (slow) begin
         if (we) begin
            ref_mem_s[addr] = wdata;
            exp_s_q.push_back(exp_s_last);
         end else begin
            exp_s_last = ref_mem_s[addr];
            exp_s_q.push_back(exp_s_last);
         end
         s_d_we = we; s_d_addr = addr; s_d_wdata = wdata; s_d_req = 1'b1;
      end else if (is_d) begin
         if (we) begin
            ref_mem[addr] = wdata;
            exp_d_q.push_back(exp_d_last);
         end else begin
            exp_d_last = ref_mem[addr];
            exp_d_q.push_back(exp_d_last);
         end
         d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
      end else begin
         exp_f_last = ref_mem[addr];
         exp_f_q.push_back(exp_f_last);
         f_addr = addr; f_req = 1'b1;
      end
      cyc = 0; strobes = 0; bad = 0; acked = 0;
      while (!acked && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         r  = slow ? s_ram_read    : ram_read;
         w  = slow ? s_ram_write   : ram_write;
         a  = slow ? s_ram_address : ram_address;
         wd = slow ? s_ram_wdata   : ram_wdata;
         ack       = slow ? s_d_ack : (is_d ? d_ack : f_ack);
         wrong_ack = slow ? s_f_ack : (is_d ? f_ack : d_ack);
         if (r || w) begin
            strobes++;
            if (a !== addr) bad++;
            if (we && wd !== wdata) bad++;
            if ((r && we) || (w && !we)) bad++;
         end
         if (wrong_ack) bad++;
         if (ack) begin
            acked = 1;
            if (slow) s_d_req = 1'b0;
            else if (is_d) d_req = 1'b0;
            else f_req = 1'b0;
         end
      end
      checkOutput({tag, "_ack_latency"}, 32'(cyc), 32'(exp_lat));
      checkOutput({tag, "_strobe_cycles"}, 32'(strobes), 32'(exp_strobes));
      checkOutput({tag, "_strobe_integrity"}, 32'(bad), 32'd0);
      got = slow ? s_d_rdata : (is_d ? d_rdata : f_rdata);
      if (slow)      checkOutput({tag, "_rdata"}, got, exp_s_q.pop_front());
      else if (is_d) checkOutput({tag, "_rdata"}, got, exp_d_q.pop_front());
      else           checkOutput({tag, "_rdata"}, got, exp_f_q.pop_front());
      if (!slow) last_grant_d = is_d;
      @(posedge clk); #1;
      checkOutput({tag, "_addr_hold"}, 32'(slow ? s_ram_address : ram_address), 32'(addr));
      checkOutput({tag, "_idle"}, 32'(slow ? s_busy : busy), 32'd0);
   endtask

   // Both ports request on the same edge; winner acked after 3 cycles, loser 4 later.
   task automatic tieTest(input string tag);
      bit first_d;
      int cyc, d_at, f_at;
`ifdef ARB_ROUND_ROBIN_EN
      first_d = !last_grant_d;
`else
      first_d = 1'b1;
`endif
      exp_d_last = ref_mem[9'h020];
      exp_f_last = ref_mem[9'h010];
      exp_d_q.push_back(exp_d_last);
      exp_f_q.push_back(exp_f_last);
      d_we = 1'b0; d_addr = 9'h020; f_addr = 9'h010;
      d_req = 1'b1; f_req = 1'b1;
      cyc = 0; d_at = 0; f_at = 0;
      while ((d_at == 0 || f_at == 0) && cyc < 20) begin
         @(posedge clk); #1;
         cyc++;
         if (d_ack && d_at == 0) begin d_at = cyc; d_req = 1'b0; end
         if (f_ack && f_at == 0) begin f_at = cyc; f_req = 1'b0; end
      end
      d_req = 1'b0; f_req = 1'b0;
      checkOutput({tag, "_d_ack_cycle"}, 32'(d_at), first_d ? 32'd3 : 32'd7);
      checkOutput({tag, "_f_ack_cycle"}, 32'(f_at), first_d ? 32'd7 : 32'd3);
      checkOutput({tag, "_d_rdata"}, d_rdata, exp_d_q.pop_front());
      checkOutput({tag, "_f_rdata"}, f_rdata, exp_f_q.pop_front());
      last_grant_d = !first_d;
      @(posedge clk); #1;
   endtask

   initial begin
      int d_cnt, f_cnt, ack_seen;
      bit first_d;

      f_req = 0; f_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
      s_f_req = 0; s_f_addr = '0; s_d_req = 0; s_d_we = 0; s_d_addr = '0; s_d_wdata = '0;
      clr = 1'b1; preload = 1'b1;
      for (int i = 0; i < 512; i++) begin
         ref_mem[i]   = initWord(i);
         ref_mem_s[i] = initWord(i);
      end
      exp_f_last = '0; exp_d_last = '0; exp_s_last = '0; last_grant_d = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      $display("[TB] reset state");
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_f_rdata", f_rdata, 32'd0);
      checkOutput("rst_d_rdata", d_rdata, 32'd0);
      checkOutput("rst_ram_address", 32'(ram_address), 32'd0);
      checkOutput("rst_ram_wdata", ram_wdata, 32'd0);
      checkOutput("rst_acks", 32'({f_ack, d_ack}), 32'd0);
      checkOutput("rst_strobes", 32'({ram_read, ram_write}), 32'd0);
      clr = 1'b0; preload = 1'b0;

      $display("[TB] fetch, load, store");
      applyStimulus("T2_fetch", 0, 0, 0, 9'h010, 32'h0);
      applyStimulus("load_020", 0, 1, 0, 9'h020, 32'h0);
      applyStimulus("T3_store", 0, 1, 1, 9'h1FF, 32'hDEAD_BEEF);
      applyStimulus("T3_load", 0, 1, 0, 9'h1FF, 32'h0);
      applyStimulus("fetch_1ff", 0, 0, 0, 9'h1FF, 32'h0);

      $display("[TB] simultaneous requests");
      tieTest("T4_tie1");
      tieTest("T4_tie2");

      $display("[TB] three wait cycles");
      applyStimulus("T5_load", 1, 1, 0, 9'h010, 32'h0);
      applyStimulus("T5_store", 1, 1, 1, 9'h0FF, 32'h5555_AAAA);
      applyStimulus("T5_reload", 1, 1, 0, 9'h0FF, 32'h0);

      $display("[TB] continuous requests on both ports");
`ifdef ARB_ROUND_ROBIN_EN
      first_d = !last_grant_d;
`else
      first_d = 1'b1;
`endif
      d_we = 1'b0; d_addr = 9'h020; f_addr = 9'h010;
      d_req = 1'b1; f_req = 1'b1;
      d_cnt = 0; f_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (d_ack) d_cnt++;
         if (f_ack) f_cnt++;
      end
      d_req = 1'b0; f_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      checkOutput("T6_d_grants", 32'(d_cnt), first_d ? 32'd2 : 32'd1);
      checkOutput("T6_f_grants", 32'(f_cnt), first_d ? 32'd1 : 32'd2);
      last_grant_d = first_d;
`else
      checkOutput("T6_d_grants", 32'(d_cnt), 32'd3);
      checkOutput("T6_f_grants", 32'(f_cnt), 32'd0);
      last_grant_d = 1'b1;
`endif
      if (d_cnt > 0) exp_d_last = ref_mem[9'h020];
      if (f_cnt > 0) exp_f_last = ref_mem[9'h010];
      @(posedge clk); #1;
      checkOutput("T6_idle_after", 32'(busy), 32'd0);

      $display("[TB] reset during a store");
      d_we = 1'b1; d_addr = 9'h005; d_wdata = 32'h0000_00AA; d_req = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("T1_write_active", 32'(ram_write), 32'd1);
      clr = 1'b1; d_req = 1'b0;
      @(posedge clk); #1;
      clr = 1'b0;
      checkOutput("T1_busy", 32'(busy), 32'd0);
      checkOutput("T1_strobes", 32'({ram_read, ram_write}), 32'd0);
      checkOutput("T1_f_rdata", f_rdata, 32'd0);
      checkOutput("T1_d_rdata", d_rdata, 32'd0);
      checkOutput("T1_ram_address", 32'(ram_address), 32'd0);
      ack_seen = 0;
      for (int c = 0; c < 5; c++) begin
         if (f_ack || d_ack) ack_seen++;
         @(posedge clk); #1;
      end
      checkOutput("T1_no_ack", 32'(ack_seen), 32'd0);
      exp_f_last = '0; exp_d_last = '0; exp_s_last = '0; last_grant_d = 1'b0;
      applyStimulus("post_reset_fetch", 0, 0, 0, 9'h1FF, 32'h0);
      applyStimulus("post_reset_load", 0, 1, 0, 9'h020, 32'h0);

      checkOutput("strobe_violations", 32'(strobe_viol), 32'd0);
      checkOutput("queues_drained", 32'(exp_f_q.size() + exp_d_q.size() + exp_s_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
